// File: rtl/i2c_master_fsm.sv
// rtl/i2c_master_fsm.sv - bit-level I2C master sequencer driving the downstream SDA data path
module i2c_master_fsm #(
    parameter int DIV      = 2,
    parameter int CNT_SIZE = 8
) (
    input  logic                i2c_core_clk_i,
    input  logic                reset_i,
    input  logic                enable_i,
    input  logic                rw_i,
    input  logic [CNT_SIZE-1:0] num_bytes_i,
    input  logic                i2c_sda_i,
    input  logic                fifo_empty_i,
    input  logic                fifo_full_i,
    output logic                i2c_scl_o,
    output logic                i2c_sda_oe_o,
    output logic                sda_low_en_o,
    output logic                write_addr_en_o,
    output logic                write_data_en_o,
    output logic                receive_data_en_o,
    output logic [3:0]          count_bit_o,
    output logic                fifo_rd_o,
    output logic                fifo_wr_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                nack_o
);

    localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_START    = 4'd1;
    localparam logic [3:0] S_ADDR     = 4'd2;
    localparam logic [3:0] S_ADDR_ACK = 4'd3;
    localparam logic [3:0] S_WR_WAIT  = 4'd4;
    localparam logic [3:0] S_WR_DATA  = 4'd5;
    localparam logic [3:0] S_WR_ACK   = 4'd6;
    localparam logic [3:0] S_RD_WAIT  = 4'd7;
    localparam logic [3:0] S_RD_DATA  = 4'd8;
    localparam logic [3:0] S_RD_ACK   = 4'd9;
    localparam logic [3:0] S_STOP     = 4'd10;

    logic [3:0]          state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic [1:0]          qtr_q, qtr_d;
    logic [2:0]          bit_q, bit_d;
    logic [CNT_SIZE-1:0] rem_q, rem_d;
    logic                rw_q, rw_d;
    logic                ack_q, ack_d;
    logic                nack_q, nack_d;
    logic                done_q, done_d;
    logic                fifo_wr_q, fifo_wr_d;

    logic running, quarter_end, bit_end, rem_zero;

    assign running     = (state_q != S_IDLE) && (state_q != S_WR_WAIT) && (state_q != S_RD_WAIT);
    assign quarter_end = (div_q == DIV_LAST);
    assign bit_end     = running && quarter_end && (qtr_q == 2'd3);
    assign rem_zero    = (rem_q == '0);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        rem_d     = rem_q;
        rw_d      = rw_q;
        ack_d     = ack_q;
        nack_d    = nack_q;
        done_d    = 1'b0;
        fifo_wr_d = 1'b0;

        // Waits freeze the quarter timing so SCL stretches low without losing phase.
        if (running) begin
            if (quarter_end) begin
                div_d = '0;
                qtr_d = qtr_q + 2'd1;
                if (qtr_q == 2'd2) begin
                    ack_d = i2c_sda_i;
                end
            end else begin
                div_d = div_q + DW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    state_d = S_START;
                    rw_d    = rw_i;
                    rem_d   = num_bytes_i;
                    nack_d  = 1'b0;
                    div_d   = '0;
                    qtr_d   = 2'd0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_ADDR;
                    bit_d   = 3'd7;
                end
            end
            S_ADDR: begin
                if (bit_end) begin
                    if (bit_q == 3'd0) state_d = S_ADDR_ACK;
                    else               bit_d   = bit_q - 3'd1;
                end
            end
            S_ADDR_ACK, S_WR_ACK: begin
                if (bit_end) begin
                    if (ack_q) begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end else if (rem_zero) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = rw_q ? S_RD_WAIT : S_WR_WAIT;
                    end
                end
            end
            S_WR_WAIT: begin
                if (!fifo_empty_i) begin
                    state_d = S_WR_DATA;
                    bit_d   = 3'd7;
                end
            end
            S_WR_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd0) begin
                        state_d = S_WR_ACK;
                        if (!rem_zero) rem_d = rem_q - CNT_SIZE'(1);
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            S_RD_WAIT: begin
                if (!fifo_full_i) begin
                    state_d = S_RD_DATA;
                    bit_d   = 3'd7;
                end
            end
            S_RD_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd0) begin
                        state_d   = S_RD_ACK;
                        fifo_wr_d = 1'b1;
                        if (!rem_zero) rem_d = rem_q - CNT_SIZE'(1);
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            S_RD_ACK: begin
                if (bit_end) state_d = rem_zero ? S_STOP : S_RD_WAIT;
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i2c_core_clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            rem_q     <= '0;
            rw_q      <= 1'b0;
            ack_q     <= 1'b0;
            nack_q    <= 1'b0;
            done_q    <= 1'b0;
            fifo_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            rem_q     <= rem_d;
            rw_q      <= rw_d;
            ack_q     <= ack_d;
            nack_q    <= nack_d;
            done_q    <= done_d;
            fifo_wr_q <= fifo_wr_d;
        end
    end

    // SCL is high in q2-q3 of every clocked bit; START keeps it high throughout.
    always_comb begin
        i2c_scl_o         = 1'b1;
        i2c_sda_oe_o      = 1'b0;
        sda_low_en_o      = 1'b0;
        write_addr_en_o   = 1'b0;
        write_data_en_o   = 1'b0;
        receive_data_en_o = 1'b0;
        count_bit_o       = 4'd0;
        fifo_rd_o         = 1'b0;
        case (state_q)
            S_START: begin
                if (qtr_q[1]) begin
                    sda_low_en_o = 1'b1;
                    i2c_sda_oe_o = 1'b1;
                end
            end
            S_ADDR: begin
                i2c_scl_o       = qtr_q[1];
                write_addr_en_o = 1'b1;
                i2c_sda_oe_o    = 1'b1;
                count_bit_o     = {1'b0, bit_q};
            end
            S_ADDR_ACK, S_WR_ACK: begin
                i2c_scl_o = qtr_q[1];
            end
            S_WR_WAIT: begin
                i2c_scl_o = 1'b0;
                fifo_rd_o = !fifo_empty_i;
            end
            S_WR_DATA: begin
                i2c_scl_o       = qtr_q[1];
                write_data_en_o = 1'b1;
                i2c_sda_oe_o    = 1'b1;
                count_bit_o     = {1'b0, bit_q};
            end
            S_RD_WAIT: begin
                i2c_scl_o = 1'b0;
            end
            S_RD_DATA: begin
                i2c_scl_o         = qtr_q[1];
                receive_data_en_o = 1'b1;
                count_bit_o       = {1'b0, bit_q};
            end
            S_RD_ACK: begin
                i2c_scl_o = qtr_q[1];
                if (!rem_zero) begin
                    sda_low_en_o = 1'b1;
                    i2c_sda_oe_o = 1'b1;
                end
            end
            S_STOP: begin
                i2c_scl_o = qtr_q[1];
                if (qtr_q != 2'd3) begin
                    sda_low_en_o = 1'b1;
                    i2c_sda_oe_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign fifo_wr_o = fifo_wr_q;
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = done_q;
    assign nack_o    = nack_q;

endmodule
